mac_accumulator: RTL

- Sequential stage directly downstream of the 4x4 combinational multiplier.
- Registers each 8-bit product {p7..p0} presented with a valid strobe and accumulates products into a wider running sum.
- Ends a frame on in_last or on reaching MAX_BEATS, then holds sum, beat count and status flags under a valid/ready handshake until the consumer takes them.
- Turns the multiplier into the multiply-accumulate datapath for dot-product work.

---
 rtl/mac_accumulator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator
// ---------------
// Multiply-accumulate back end for the 4x4 combinational multiplier. Each
// accepted product beat is added into a running sum. A frame closes on
// in_last or when the beat count reaches MAX_BEATS. The completed sum, the
// beat count and the status flags are then held under a valid/ready
// handshake until the consumer takes them.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   prod       in   PROD_W product beat
//   in_valid   in   prod/in_last valid this cycle
//   in_last    in   beat closes the frame
//   in_ready   out  block accepts a beat this cycle (ACCUM state, not in reset)
//   out_valid  out  result registers hold a completed frame
//   out_ready  in   consumer takes the result
//   out_sum    out  frame sum modulo 2^ACC_W
//   out_count  out  beats in the frame
//   out_ovf    out  a carry out of ACC_W occurred somewhere in the frame
//   out_trunc  out  frame closed by MAX_BEATS rather than in_last
module mac_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              out_trunc
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Count value of the beat that forces a frame to close.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BEATS - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_trunc_q, out_trunc_d;

  logic               accept;
  logic [ACC_W:0]     sum;
  logic [CNT_W-1:0]   count_inc;
  logic               ovf_next;
  logic               frame_end;

  // Ready depends only on state and reset so an upstream stage can never
  // form a combinational loop through in_valid.
  assign in_ready  = !rst && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;

  // One extra bit catches the carry out of the accumulator.
  assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
  assign ovf_next  = sum[ACC_W] | ovf_q;
  assign count_inc = count_q + CNT_W'(1);
  assign frame_end = in_last || (count_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (frame_end) begin
            out_sum_d   = sum[ACC_W-1:0];
            out_count_d = count_inc;
            out_ovf_d   = ovf_next;
            out_trunc_d = !in_last;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            ovf_d       = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d   = sum[ACC_W-1:0];
            count_d = count_inc;
            ovf_d   = ovf_next;
          end
        end
      end
      DONE: begin
        // Data registers keep their values after the handshake; only the
        // valid flag drops.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;
  assign out_trunc = out_trunc_q;

endmodule
